// File: rtl/snake_body_engine.sv
// snake_body_engine
// Holds the snake body as a head-first list of grid cells and advances it one
// cell per step pulse. Handles growth, reversal-proof steering, wall/wrap
// boundaries, self/wall collision and a registered per-cell occupancy query.
//
// Ports:
//   clk               system clock, all state updates on its rising edge
//   reset             synchronous active-high, loads the initial snake
//   restart           one-cycle pulse, same effect as reset for this block
//   step              one-cycle pulse, advance the body one cell
//   dir_valid/dir_req direction request (0 up, 1 down, 2 left, 3 right)
//   grow              one-cycle pulse, next accepted step lengthens the snake
//   qx/qy             query cell; q_hit/q_head answer one cycle later
//   head_x/head_y     head cell
//   length            live segment count
//   dead/died         collision level / one-cycle collision pulse
module snake_body_engine #(
  parameter int unsigned GRID_W   = 64,
  parameter int unsigned GRID_H   = 48,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 4,
  parameter int unsigned WRAP     = 0,
  localparam int unsigned XW = $clog2(GRID_W),
  localparam int unsigned YW = $clog2(GRID_H),
  localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          step,
  input  logic          dir_valid,
  input  logic [1:0]    dir_req,
  input  logic          grow,
  input  logic [XW-1:0] qx,
  input  logic [YW-1:0] qy,
  output logic          q_hit,
  output logic          q_head,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          dead,
  output logic          died
);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];
  logic [LW-1:0] len_r;
  logic [1:0]    dir_r;
  logic [1:0]    moved_dir;
  logic          grow_pend;

  logic          req_legal;
  logic [1:0]    eff_dir;
  logic          grow_now;
  logic [XW-1:0] nh_x;
  logic [YW-1:0] nh_y;
  logic          wall_hit;
  logic          self_hit;
  logic          q_match;

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
  assign length = len_r;

  // Up/down and left/right differ only in bit 0, so the reverse is dir ^ 1.
  assign req_legal = dir_req != (moved_dir ^ 2'd1);
  assign eff_dir   = (dir_valid && req_legal) ? dir_req : dir_r;
  // The tail only stays put when the step really lengthens the snake.
  assign grow_now  = (grow_pend || grow) && (len_r < LW'(MAX_LEN));

  // Next head cell with explicit edge compares (grid need not be a power of 2).
  always_comb begin
    nh_x     = seg_x[0];
    nh_y     = seg_y[0];
    wall_hit = 1'b0;
    case (eff_dir)
      DIR_UP: begin
        if (seg_y[0] == '0) begin
          if (WRAP != 0) nh_y = YW'(GRID_H - 1);
          else           wall_hit = 1'b1;
        end else begin
          nh_y = seg_y[0] - YW'(1);
        end
      end
      DIR_DOWN: begin
        if (seg_y[0] == YW'(GRID_H - 1)) begin
          if (WRAP != 0) nh_y = '0;
          else           wall_hit = 1'b1;
        end else begin
          nh_y = seg_y[0] + YW'(1);
        end
      end
      DIR_LEFT: begin
        if (seg_x[0] == '0) begin
          if (WRAP != 0) nh_x = XW'(GRID_W - 1);
          else           wall_hit = 1'b1;
        end else begin
          nh_x = seg_x[0] - XW'(1);
        end
      end
      default: begin
        if (seg_x[0] == XW'(GRID_W - 1)) begin
          if (WRAP != 0) nh_x = '0;
          else           wall_hit = 1'b1;
        end else begin
          nh_x = seg_x[0] + XW'(1);
        end
      end
    endcase
  end

  // Self collision against live body; the vacating tail is exempt unless growing.
  always_comb begin
    self_hit = 1'b0;
    for (int unsigned i = 1; i < MAX_LEN; i++) begin
      if ((LW'(i) < len_r) && (grow_now || (LW'(i + 1) != len_r))) begin
        if ((seg_x[i] == nh_x) && (seg_y[i] == nh_y)) self_hit = 1'b1;
      end
    end
  end

  // Occupancy of the query cell by any live segment.
  always_comb begin
    q_match = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < len_r) && (seg_x[i] == qx) && (seg_y[i] == qy)) q_match = 1'b1;
    end
  end

  // Body, direction, growth, collision and query state.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) seg_x[i] <= XW'(INIT_LEN - 1 - i);
        else              seg_x[i] <= '0;
        seg_y[i] <= '0;
      end
      len_r     <= LW'(INIT_LEN);
      dir_r     <= DIR_RIGHT;
      moved_dir <= DIR_RIGHT;
      grow_pend <= 1'b0;
      dead      <= 1'b0;
      died      <= 1'b0;
      q_hit     <= 1'b0;
      q_head    <= 1'b0;
    end else begin
      died   <= 1'b0;
      q_hit  <= q_match;
      q_head <= (seg_x[0] == qx) && (seg_y[0] == qy);
      if (!dead) begin
        if (dir_valid && req_legal) dir_r <= dir_req;
        if (grow) grow_pend <= 1'b1;
        if (step) begin
          grow_pend <= 1'b0;
          if (wall_hit || self_hit) begin
            dead <= 1'b1;
            died <= 1'b1;
          end else begin
            for (int unsigned i = 1; i < MAX_LEN; i++) begin
              seg_x[i] <= seg_x[i - 1];
              seg_y[i] <= seg_y[i - 1];
            end
            seg_x[0]  <= nh_x;
            seg_y[0]  <= nh_y;
            moved_dir <= eff_dir;
            if (grow_now) len_r <= len_r + LW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: two instances (64x48 walls, and a 6x5 wrapping
// grid capped at 4 segments) share the control stimulus. A queue-based body
// model predicts every output each cycle; per-instance monitors compare.
module tb_snake_body_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       restart = 1'b0;
  logic       step = 1'b0;
  logic       dir_valid = 1'b0;
  logic [1:0] dir_req = 2'd0;
  logic       grow = 1'b0;
  bit         running = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int hx;
    int hy;
    int len;
    bit dead;
    bit died;
    bit qh;
    bit qhd;
  } exp_t;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int opp(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int dxs(input int d);
    return (d == 2) ? -1 : ((d == 3) ? 1 : 0);
  endfunction

  function automatic int dys(input int d);
    return (d == 0) ? -1 : ((d == 1) ? 1 : 0);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int GW = (g == 0) ? 64 : 6;
    localparam int GH = (g == 0) ? 48 : 5;
    localparam int ML = (g == 0) ? 16 : 4;
    localparam int WR = (g == 0) ? 0 : 1;
    localparam int XW = $clog2(GW);
    localparam int YW = $clog2(GH);
    localparam int LW = $clog2(ML + 1);

    logic [XW-1:0] qx = '0;
    logic [YW-1:0] qy = '0;
    logic          q_hit, q_head, dead, died;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [LW-1:0] len_o;

    snake_body_engine #(
      .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(4), .WRAP(WR)
    ) dut (
      .clk(clk), .reset(reset), .restart(restart), .step(step),
      .dir_valid(dir_valid), .dir_req(dir_req), .grow(grow),
      .qx(qx), .qy(qy), .q_hit(q_hit), .q_head(q_head),
      .head_x(head_x), .head_y(head_y), .length(len_o),
      .dead(dead), .died(died)
    );

    exp_t exp_q[$];
    int   bx[$];
    int   by[$];
    int   m_dir, m_moved;
    bit   m_gp, m_dead;

    // Query stimulus biased toward body cells and the cell ahead of the head.
    always begin
      int r, k;
      @(posedge clk); #2;
      r = $urandom_range(0, 3);
      if (bx.size() == 0 || r == 3) begin
        qx = XW'($urandom);
        qy = YW'($urandom);
      end else if (r == 2) begin
        qx = XW'(bx[0] + 1);
        qy = YW'(by[0]);
      end else begin
        k  = $urandom_range(0, bx.size() - 1);
        qx = XW'(bx[k]);
        qy = YW'(by[k]);
      end
    end

    // Reference model: body is a head-first queue of cells.
    always begin
      exp_t e;
      int nx, ny, eff, sz;
      bit legal, keep, hit;
      @(posedge clk); #3;
      if (running) begin
        e.died = 1'b0;
        e.qh   = 1'b0;
        e.qhd  = 1'b0;
        if (reset || restart) begin
          bx.delete();
          by.delete();
          for (int i = 0; i < 4; i++) begin
            bx.push_back(3 - i);
            by.push_back(0);
          end
          m_dir = 3; m_moved = 3; m_gp = 1'b0; m_dead = 1'b0;
        end else begin
          for (int i = 0; i < bx.size(); i++)
            if (bx[i] == int'(qx) && by[i] == int'(qy)) e.qh = 1'b1;
          e.qhd = (bx[0] == int'(qx)) && (by[0] == int'(qy));
          if (!m_dead) begin
            legal = dir_valid && (int'(dir_req) != opp(m_moved));
            eff   = legal ? int'(dir_req) : m_dir;
            if (step) begin
              nx  = bx[0] + dxs(eff);
              ny  = by[0] + dys(eff);
              hit = 1'b0;
              if (WR != 0) begin
                nx = (nx + GW) % GW;
                ny = (ny + GH) % GH;
              end else if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                hit = 1'b1;
              end
              sz   = bx.size();
              keep = (m_gp || grow) && (sz < ML);
              for (int i = 1; i < sz; i++)
                if ((i < sz - 1 || keep) && bx[i] == nx && by[i] == ny) hit = 1'b1;
              if (hit) begin
                m_dead = 1'b1;
                e.died = 1'b1;
              end else begin
                bx.push_front(nx);
                by.push_front(ny);
                if (!keep) begin
                  void'(bx.pop_back());
                  void'(by.pop_back());
                end
                m_moved = eff;
              end
              m_gp = 1'b0;
            end else if (grow) begin
              m_gp = 1'b1;
            end
            if (legal) m_dir = int'(dir_req);
          end
        end
        e.hx   = bx[0];
        e.hy   = by[0];
        e.len  = bx.size();
        e.dead = m_dead;
        exp_q.push_back(e);
      end
    end

    // Monitor: one expected record per clock once stimulus is running.
    always begin
      exp_t m;
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        chk($sformatf("u%0d.head_x", g), int'(head_x), m.hx);
        chk($sformatf("u%0d.head_y", g), int'(head_y), m.hy);
        chk($sformatf("u%0d.length", g), int'(len_o), m.len);
        chk($sformatf("u%0d.dead", g), int'(dead), int'(m.dead));
        chk($sformatf("u%0d.died", g), int'(died), int'(m.died));
        chk($sformatf("u%0d.q_hit", g), int'(q_hit), int'(m.qh));
        chk($sformatf("u%0d.q_head", g), int'(q_head), int'(m.qhd));
      end
    end
  end

  task automatic drive(input bit rst, input bit rs, input bit st, input bit dv,
                       input logic [1:0] dr, input bit gr);
    @(posedge clk); #2;
    running   = 1'b1;
    reset     = rst;
    restart   = rs;
    step      = st;
    dir_valid = dv;
    dir_req   = dr;
    grow      = gr;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    drive(1, 0, 0, 0, 2'd0, 0);
    // Three steps right, then a rejected reversal riding on a step.
    repeat (3) drive(0, 0, 1, 0, 2'd0, 0);
    drive(0, 0, 1, 1, 2'd2, 0);
    // Turn down, step, turn left, step.
    drive(0, 0, 0, 1, 2'd1, 0);
    drive(0, 0, 1, 0, 2'd0, 0);
    drive(0, 0, 0, 1, 2'd2, 0);
    drive(0, 0, 1, 0, 2'd0, 0);
    // Two quick turns between steps: up then right (reverse of left) is dropped.
    drive(0, 0, 0, 1, 2'd0, 0);
    drive(0, 0, 0, 1, 2'd3, 0);
    drive(0, 0, 1, 0, 2'd0, 0);
    // Run right into the wall (or wrap), then restart together with a step.
    drive(0, 1, 0, 0, 2'd0, 0);
    repeat (62) drive(0, 0, 1, 0, 2'd0, 0);
    drive(0, 1, 1, 0, 2'd0, 0);
    drive(0, 0, 0, 0, 2'd0, 0);
    // 2x2 loop chasing the tail, without and then with growth.
    drive(0, 0, 1, 0, 2'd0, 0);
    drive(0, 0, 1, 1, 2'd1, 0);
    drive(0, 0, 1, 1, 2'd2, 0);
    drive(0, 0, 1, 1, 2'd0, 0);
    drive(0, 1, 0, 0, 2'd0, 0);
    drive(0, 0, 1, 0, 2'd0, 0);
    drive(0, 0, 1, 1, 2'd1, 0);
    drive(0, 0, 1, 1, 2'd2, 0);
    drive(0, 0, 0, 0, 2'd0, 1);
    drive(0, 0, 1, 1, 2'd0, 0);
    // Growth: one pulse, two steps; grow on the same cycle as a step.
    drive(0, 1, 0, 0, 2'd0, 0);
    drive(0, 0, 0, 0, 2'd0, 1);
    drive(0, 0, 1, 0, 2'd0, 0);
    drive(0, 0, 1, 0, 2'd0, 0);
    drive(0, 0, 1, 0, 2'd0, 1);
    drive(0, 0, 0, 0, 2'd0, 0);
    // Randomised play.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 999) < 3, $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 35,
            2'($urandom), $urandom_range(0, 99) < 10);
    end
    @(posedge clk); #2;
    running   = 1'b0;
    reset     = 1'b0;
    restart   = 1'b0;
    step      = 1'b0;
    dir_valid = 1'b0;
    grow      = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
